reg_state_ckpt: RTL and testbench
=================================

// Module: reg_state_ckpt
// PURPOSE
//  Parametrised ASCON state register. Successor to the plain enabled D register:
//   - per-word write masks
//   - in-place XOR absorb modes: full state, or a single word
//   - synchronous clear
//   - LIFO checkpoint stack (depth SNAP_DEPTH) to save and roll back the state
//  Sits between the permutation datapath and the FSM. Used for absorb/squeeze and
//  for rollback of the state on tag-check replay.
// PARAMETERS
//  NB_WORDS    5   number of state words (ASCON: 5)
//  WORD_W      64  bits per state word
//  SNAP_DEPTH  2   checkpoint stack entries (>=1)
//  CNT_W       $clog2(SNAP_DEPTH+1)  stack occupancy width (derived, localparam)
// PORTS
//  clock_i      in   1                  rising-edge clock
//  resetb_i     in   1                  async reset, active low
//  mode_i       in   3                  state_mode_t write mode (see BEHAVIOUR)
//  word_en_i    in   NB_WORDS           per-word mask for M_LOAD / M_XOR
//  word_sel_i   in   $clog2(NB_WORDS)   target word for M_XOR_IN
//  d_i          in   NB_WORDS*WORD_W    full-state input; word 0 = bits [WORD_W-1:0]
//  data_i       in   WORD_W             single-word absorb input
//  snap_push_i  in   1                  save current q_o on top of stack
//  snap_pop_i   in   1                  restore q_o from top of stack
//  q_o          out  NB_WORDS*WORD_W    registered state
//  upd_o        out  1                  1-cycle pulse: q_o written last edge
//  snap_cnt_o   out  CNT_W              stack occupancy
//  snap_full_o  out  1                  snap_cnt_o == SNAP_DEPTH (combinational)
//  snap_empty_o out  1                  snap_cnt_o == 0 (combinational)
//  err_o        out  1                  1-cycle pulse: illegal stack request
// BEHAVIOUR
//  Reset (resetb_i=0, async): q_o=0, every stack entry=0, snap_cnt_o=0, upd_o=0, err_o=0.
//  All updates on the rising edge of clock_i. Latency is 1 cycle: q_o reflects the request from the previous edge.
//  Modes:
//   M_HOLD=0    q unchanged
//   M_LOAD=1    q[w] <= d_i[w] where word_en_i[w]=1
//   M_XOR=2     q[w] <= q[w]^d_i[w] where word_en_i[w]=1
//   M_XOR_IN=3  q[word_sel_i] <= q[word_sel_i]^data_i; word_sel_i>=NB_WORDS -> no write, err_o=1
//   M_CLEAR=4   q <= 0; stack untouched
//   5..7        treated as M_HOLD
//  Stack operation priority: pop > push > mode.
//  Push:
//   - stack[cnt] <= q_o (value before this edge); cnt+1
//   - mode still applies to q in the same cycle
//  Pop, stack not empty:
//   - q <= stack[cnt-1]; cnt-1
//   - mode is ignored this cycle
//  Push+pop asserted together:
//   - pop only; push dropped; err_o=1
//  Push with full stack:
//   - no stack change; err_o=1
//   - mode still applies
//  Pop with empty stack:
//   - no q or stack change; err_o=1
//   - mode ignored
//  upd_o=1 the cycle after any edge that wrote q. A write includes:
//   - M_CLEAR
//   - a successful pop
//   - M_LOAD / M_XOR with word_en_i != 0
//   - a legal M_XOR_IN
//  upd_o=1 even if the written value equals the old value.
//  Reset mid-operation drops any pending request; no partial write is ever visible.
// STRUCTURE
//  ascon_pack:
//   - state_mode_t enum (M_HOLD..M_CLEAR)
//   - default NB_WORDS/WORD_W constants
//   - type_state is kept unchanged for the 5x64 instance
//  Sub-module snap_lifo #(NB_WORDS*WORD_W, SNAP_DEPTH):
//   - owns stack storage, count, full/empty flags
//   - push/pop with error flag
//  Top module owns the word-masked write/XOR logic and the q register.
// TESTING
//  1 reset with inputs toggling -> q_o=0, cnt=0, empty=1, full=0, err_o=0, upd_o=0
//  2 M_LOAD d_i words 0..4 = 1..5, word_en=5'b10101
//    -> words 0,2,4 = 1,3,5; words 1,3 = 0; upd_o=1 next cycle
//  3 then M_XOR_IN sel=2 data=0xFF -> word2 = 0xFC
//    then sel=5 -> state unchanged, err_o=1, upd_o=0
//  4 M_LOAD word 0 = 0xAA with push same edge
//    -> stack top = old word0 (1), q word0 = 0xAA
//    -> pop restores word0 = 1, cnt 1->0
//  5 push x2 (DEPTH=2) -> full=1; 3rd push -> err_o=1, cnt stays 2
//    pop x2 -> LIFO order; 3rd pop -> err_o=1, q unchanged
//  6 push+pop same cycle with cnt=1 -> pop wins, cnt=0, err_o=1
//    resetb_i low mid-sequence -> all outputs back to reset values immediately

Source files
------------

// File: rtl/ascon_pack.sv
// Shared ASCON state-register types.
// Write modes and default state geometry.
package ascon_pack;

  localparam int NB_WORDS_D = 5;
  localparam int WORD_W_D   = 64;

  typedef enum logic [2:0] {
    M_HOLD   = 3'd0,
    M_LOAD   = 3'd1,
    M_XOR    = 3'd2,
    M_XOR_IN = 3'd3,
    M_CLEAR  = 3'd4
  } state_mode_t;

  typedef logic [NB_WORDS_D*WORD_W_D-1:0] type_state;

endpackage

// File: rtl/snap_lifo.sv
// Checkpoint LIFO for the ASCON state register.
// Pop beats push; illegal requests raise a combinational error.
module snap_lifo
  import ascon_pack::*;
#(
  parameter  int W     = NB_WORDS_D*WORD_W_D,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     top_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt == CNT_W'(DEPTH));
  assign empty_o = (cnt == '0);
  assign cnt_o   = cnt;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~pop_i & ~full_o;
  assign err_o   = (push_i & pop_i) | (pop_i & empty_o) | (push_i & full_o);

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CNT_W'(i + 1) == cnt) top_o = mem[i];
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_pop) begin
      cnt <= cnt - CNT_W'(1);
    end else if (do_push) begin
      for (int i = 0; i < DEPTH; i++)
        if (CNT_W'(i) == cnt) mem[i] <= din_i;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_state_ckpt.sv
// ASCON state register with masked load/XOR absorb,
// clear, and a LIFO checkpoint stack for rollback.
module reg_state_ckpt
  import ascon_pack::*;
#(
  parameter  int NB_WORDS   = NB_WORDS_D,
  parameter  int WORD_W     = WORD_W_D,
  parameter  int SNAP_DEPTH = 2,
  localparam int CNT_W      = $clog2(SNAP_DEPTH+1),
  localparam int SEL_W      = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1,
  localparam int ST_W       = NB_WORDS*WORD_W
) (
  input  logic                clock_i,
  input  logic                resetb_i,
  input  logic [2:0]          mode_i,
  input  logic [NB_WORDS-1:0] word_en_i,
  input  logic [SEL_W-1:0]    word_sel_i,
  input  logic [ST_W-1:0]     d_i,
  input  logic [WORD_W-1:0]   data_i,
  input  logic                snap_push_i,
  input  logic                snap_pop_i,
  output logic [ST_W-1:0]     q_o,
  output logic                upd_o,
  output logic [CNT_W-1:0]    snap_cnt_o,
  output logic                snap_full_o,
  output logic                snap_empty_o,
  output logic                err_o
);

  state_mode_t     mode;
  logic [ST_W-1:0] q;
  logic [ST_W-1:0] q_n;
  logic [ST_W-1:0] top;
  logic            wr;
  logic            sel_ok;
  logic            sel_err;
  logic            stk_err;

  assign mode = state_mode_t'(mode_i);
  assign q_o  = q;

  snap_lifo #(
    .W     (ST_W),
    .DEPTH (SNAP_DEPTH)
  ) u_lifo (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .push_i   (snap_push_i),
    .pop_i    (snap_pop_i),
    .din_i    (q),
    .top_o    (top),
    .cnt_o    (snap_cnt_o),
    .full_o   (snap_full_o),
    .empty_o  (snap_empty_o),
    .err_o    (stk_err)
  );

  // A pop (even a failed one) suppresses the mode for this edge
  always_comb begin
    q_n     = q;
    wr      = 1'b0;
    sel_ok  = 1'b0;
    sel_err = 1'b0;
    if (snap_pop_i) begin
      if (!snap_empty_o) begin
        q_n = top;
        wr  = 1'b1;
      end
    end else begin
      case (mode)
        M_LOAD: begin
          for (int w = 0; w < NB_WORDS; w++)
            if (word_en_i[w])
              q_n[w*WORD_W +: WORD_W] = d_i[w*WORD_W +: WORD_W];
          wr = |word_en_i;
        end
        M_XOR: begin
          for (int w = 0; w < NB_WORDS; w++)
            if (word_en_i[w])
              q_n[w*WORD_W +: WORD_W] = q[w*WORD_W +: WORD_W]
                                      ^ d_i[w*WORD_W +: WORD_W];
          wr = |word_en_i;
        end
        M_XOR_IN: begin
          for (int w = 0; w < NB_WORDS; w++)
            if (SEL_W'(w) == word_sel_i) begin
              q_n[w*WORD_W +: WORD_W] = q[w*WORD_W +: WORD_W] ^ data_i;
              sel_ok = 1'b1;
            end
          wr      = sel_ok;
          sel_err = ~sel_ok;
        end
        M_CLEAR: begin
          q_n = '0;
          wr  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      q     <= '0;
      upd_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      q     <= q_n;
      upd_o <= wr;
      err_o <= stk_err | sel_err;
    end
  end

endmodule

// File: tb/tb_reg_state_ckpt.sv
// Bench for reg_state_ckpt: directed literal checks
// plus randomized traffic against a queue-based model.
module tb_reg_state_ckpt;

  localparam int NW    = 5;
  localparam int WW    = 64;
  localparam int DEPTH = 2;
  localparam int SW    = NW*WW;

  logic          clk = 1'b0;
  logic          resetb;
  logic [2:0]    mode;
  logic [NW-1:0] en;
  logic [2:0]    sel;
  logic [SW-1:0] d;
  logic [WW-1:0] data;
  logic          push;
  logic          pop;
  logic [SW-1:0] q_o;
  logic          upd_o;
  logic [1:0]    cnt_o;
  logic          full_o;
  logic          empty_o;
  logic          err_o;

  int nvec = 0;
  int nerr = 0;
  logic chk_en = 1'b0;

  logic [SW-1:0] mq;
  logic [SW-1:0] mstk[$];
  logic          e_upd;
  logic          e_err;

  reg_state_ckpt #(
    .NB_WORDS   (NW),
    .WORD_W     (WW),
    .SNAP_DEPTH (DEPTH)
  ) dut (
    .clock_i      (clk),
    .resetb_i     (resetb),
    .mode_i       (mode),
    .word_en_i    (en),
    .word_sel_i   (sel),
    .d_i          (d),
    .data_i       (data),
    .snap_push_i  (push),
    .snap_pop_i   (pop),
    .q_o          (q_o),
    .upd_o        (upd_o),
    .snap_cnt_o   (cnt_o),
    .snap_full_o  (full_o),
    .snap_empty_o (empty_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [SW-1:0] a,
                     input logic [SW-1:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [WW-1:0] wq(input int k);
    return q_o[k*WW +: WW];
  endfunction

  function automatic logic [SW-1:0] pack5(input logic [WW-1:0] w0, w1,
                                          w2, w3, w4);
    return {w4, w3, w2, w1, w0};
  endfunction

  task automatic model_reset();
    mq = '0;
    mstk.delete();
    e_upd = 1'b0;
    e_err = 1'b0;
  endtask

  // What one edge must do, from the register's rules
  task automatic model_edge();
    logic [SW-1:0] old;
    int s;
    old   = mq;
    e_upd = 1'b0;
    e_err = 1'b0;
    if (pop) begin
      if (push) e_err = 1'b1;
      if (mstk.size() == 0) e_err = 1'b1;
      else begin
        mq    = mstk.pop_back();
        e_upd = 1'b1;
      end
    end else begin
      if (push) begin
        if (mstk.size() == DEPTH) e_err = 1'b1;
        else mstk.push_back(old);
      end
      case (mode)
        3'd1: begin
          for (int w = 0; w < NW; w++)
            if (en[w]) mq[w*WW +: WW] = d[w*WW +: WW];
          e_upd = (en != 0);
        end
        3'd2: begin
          for (int w = 0; w < NW; w++)
            if (en[w]) mq[w*WW +: WW] = old[w*WW +: WW] ^ d[w*WW +: WW];
          e_upd = (en != 0);
        end
        3'd3: begin
          s = int'(sel);
          if (s < NW) begin
            mq[s*WW +: WW] = old[s*WW +: WW] ^ data;
            e_upd = 1'b1;
          end else e_err = 1'b1;
        end
        3'd4: begin
          mq = '0;
          e_upd = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("q", q_o, mq);
      cmp("upd", SW'(upd_o), SW'(e_upd));
      cmp("err", SW'(err_o), SW'(e_err));
      cmp("cnt", SW'(cnt_o), SW'(mstk.size()));
      cmp("full", SW'(full_o), SW'(mstk.size() == DEPTH));
      cmp("empty", SW'(empty_o), SW'(mstk.size() == 0));
    end
  end

  task automatic step(input logic [2:0] m, input logic [NW-1:0] e,
                      input logic [2:0] s, input logic [SW-1:0] dd,
                      input logic [WW-1:0] dt, input logic pu,
                      input logic po);
    mode = m; en = e; sel = s; d = dd; data = dt; push = pu; pop = po;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_in();
    mode = 3'($urandom_range(0, 7));
    en   = NW'($urandom);
    sel  = 3'($urandom);
    for (int k = 0; k < SW/32; k++) d[k*32 +: 32] = $urandom;
    data = {$urandom, $urandom};
    push = ($urandom_range(0, 3) == 0);
    pop  = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    logic [SW-1:0] dv;
    resetb = 1'b0;
    model_reset();
    rand_in();
    chk_en = 1'b1;
    // 1: reset holds with inputs toggling
    repeat (3) begin
      @(posedge clk);
      #1 rand_in();
    end
    @(negedge clk);
    #1;
    cmp("rst_q", q_o, '0);
    cmp("rst_cnt", SW'(cnt_o), '0);
    cmp("rst_empty", SW'(empty_o), SW'(1));
    cmp("rst_full", SW'(full_o), '0);
    cmp("rst_err", SW'(err_o), '0);
    cmp("rst_upd", SW'(upd_o), '0);
    resetb = 1'b1;

    // 2: masked load
    dv = pack5(64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
    step(3'd1, 5'b10101, 3'd0, dv, '0, 1'b0, 1'b0);
    cmp("ld_q", q_o, pack5(64'd1, 64'd0, 64'd3, 64'd0, 64'd5));
    cmp("ld_upd", SW'(upd_o), SW'(1));

    // 3: single-word absorb, then illegal select
    step(3'd3, '0, 3'd2, '0, 64'hFF, 1'b0, 1'b0);
    cmp("xin_w2", SW'(wq(2)), SW'(64'hFC));
    step(3'd3, '0, 3'd5, '0, 64'hFF, 1'b0, 1'b0);
    cmp("xbad_w2", SW'(wq(2)), SW'(64'hFC));
    cmp("xbad_err", SW'(err_o), SW'(1));
    cmp("xbad_upd", SW'(upd_o), '0);

    // 4: load with push, then pop rolls back
    step(3'd1, 5'b00001, 3'd0, SW'(64'hAA), '0, 1'b1, 1'b0);
    cmp("lp_w0", SW'(wq(0)), SW'(64'hAA));
    cmp("lp_cnt", SW'(cnt_o), SW'(1));
    step(3'd0, '0, 3'd0, '0, '0, 1'b0, 1'b1);
    cmp("pop_w0", SW'(wq(0)), SW'(64'd1));
    cmp("pop_cnt", SW'(cnt_o), '0);

    // 5: fill, overflow, drain in LIFO order, underflow
    step(3'd1, 5'b00001, 3'd0, SW'(64'h11), '0, 1'b1, 1'b0);
    step(3'd1, 5'b00001, 3'd0, SW'(64'h22), '0, 1'b1, 1'b0);
    cmp("full", SW'(full_o), SW'(1));
    step(3'd0, '0, 3'd0, '0, '0, 1'b1, 1'b0);
    cmp("ovf_err", SW'(err_o), SW'(1));
    cmp("ovf_cnt", SW'(cnt_o), SW'(2));
    step(3'd0, '0, 3'd0, '0, '0, 1'b0, 1'b1);
    cmp("pop1_w0", SW'(wq(0)), SW'(64'h11));
    step(3'd0, '0, 3'd0, '0, '0, 1'b0, 1'b1);
    cmp("pop2_w0", SW'(wq(0)), SW'(64'd1));
    step(3'd4, '0, 3'd0, '0, '0, 1'b0, 1'b1);
    cmp("unf_err", SW'(err_o), SW'(1));
    cmp("unf_w0", SW'(wq(0)), SW'(64'd1));
    cmp("unf_upd", SW'(upd_o), '0);

    // 6: push+pop together, then async reset mid-run
    step(3'd0, '0, 3'd0, '0, '0, 1'b1, 1'b0);
    step(3'd4, '0, 3'd0, '0, '0, 1'b1, 1'b1);
    cmp("pp_cnt", SW'(cnt_o), '0);
    cmp("pp_err", SW'(err_o), SW'(1));
    cmp("pp_w0", SW'(wq(0)), SW'(64'd1));
    step(3'd0, '0, 3'd0, '0, '0, 1'b1, 1'b0);
    #2;
    resetb = 1'b0;
    model_reset();
    #1;
    cmp("arst_q", q_o, '0);
    cmp("arst_cnt", SW'(cnt_o), '0);
    cmp("arst_empty", SW'(empty_o), SW'(1));
    rand_in();
    @(negedge clk);
    #1 resetb = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_in();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
